// File: rtl/bulk_read_arbiter_if.sv
// Request/response channel between a bulk reader and its memory side.
// master drives requests; slave accepts them and returns responses.
interface bulk_read_interface #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINE_SIZE = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_write;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  dumping_cache;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/bulk_read_arbiter.sv
// Round-robin N:1 read arbiter with grant lock, cache-dump priority and in-order
// response routing. Define BULK_ARB_PERF_EN to add per-channel grant counters.
module bulk_read_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bulk_read_interface.slave  ch [NUM_CH],
    bulk_read_interface.master mem,
    output logic               resp_err
`ifdef BULK_ARB_PERF_EN
   ,output logic [31:0]        grant_count [NUM_CH]
`endif
);
    localparam int ADDR_W = $bits(mem.req_addr);
    localparam int DATA_W = $bits(mem.req_wdata);
    localparam int STRB_W = $bits(mem.req_wstrb);
    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam idx_t LAST_CH  = idx_t'(NUM_CH - 1);
    localparam ptr_t LAST_PTR = ptr_t'(MAX_OUTSTANDING - 1);
    localparam cnt_t FULL_CNT = cnt_t'(MAX_OUTSTANDING);

    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_dump;
    logic [NUM_CH-1:0] ch_write;
    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];
    logic [STRB_W-1:0] ch_wstrb [NUM_CH];
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_resp;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_valid[i]      = ch[i].req_valid;
        assign ch_dump[i]       = ch[i].dumping_cache;
        assign ch_write[i]      = ch[i].req_write;
        assign ch_addr[i]       = ch[i].req_addr;
        assign ch_wdata[i]      = ch[i].req_wdata;
        assign ch_wstrb[i]      = ch[i].req_wstrb;
        assign ch[i].req_ready  = ch_ready[i];
        assign ch[i].resp_valid = ch_resp[i];
        assign ch[i].resp_rdata = mem.resp_rdata;
    end

    idx_t rr_ptr;
    logic lock;
    idx_t lock_ch;
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count;
    idx_t fifo_mem [2**PTR_W];

    logic              dump_any;
    idx_t              dump_idx;
    logic [NUM_CH-1:0] eligible;
    logic              rr_found;
    idx_t              rr_idx;
    idx_t              probe;
    logic              grant_vld;
    idx_t              grant_idx;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        dump_any  = |ch_dump;
        dump_idx  = '0;
        rr_found  = 1'b0;
        rr_idx    = '0;
        probe     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_dump[i]) dump_idx = idx_t'(i);
        end
        eligible = dump_any ? (ch_valid & (NUM_CH'(1) << dump_idx)) : ch_valid;
        for (int off = 0; off < NUM_CH; off++) begin
            probe = (int'(rr_ptr) + off >= NUM_CH) ? idx_t'(int'(rr_ptr) + off - NUM_CH)
                                                   : idx_t'(int'(rr_ptr) + off);
            if (!rr_found && eligible[probe]) begin
                rr_found = 1'b1;
                rr_idx   = probe;
            end
        end
        // A stalled request keeps its grant regardless of dump masking.
        if (lock && ch_valid[lock_ch]) begin
            grant_vld = 1'b1;
            grant_idx = lock_ch;
        end else begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end
    end

    logic fifo_full;
    logic fifo_empty;
    logic issue;
    logic accept;
    logic pop;
    idx_t head;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign issue      = rst_n && grant_vld && !fifo_full;
    assign accept     = issue && mem.req_ready;
    assign pop        = mem.resp_valid && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    assign mem.req_valid     = issue;
    assign mem.req_addr      = issue ? ch_addr[grant_idx]  : '0;
    assign mem.req_write     = issue ? ch_write[grant_idx] : 1'b0;
    assign mem.req_wdata     = issue ? ch_wdata[grant_idx] : '0;
    assign mem.req_wstrb     = issue ? ch_wstrb[grant_idx] : '0;
    assign mem.dumping_cache = dump_any;

    always_comb begin
        ch_ready = '0;
        ch_resp  = '0;
        if (rst_n && grant_vld) ch_ready[grant_idx] = mem.req_ready && !fifo_full;
        if (rst_n && pop)       ch_resp[head]       = 1'b1;
    end

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: state registers use <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_ch  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                lock   <= 1'b0;
            end else if (issue) begin
                lock    <= 1'b1;
                lock_ch <= grant_idx;
            end else if (lock && !ch_valid[lock_ch]) begin
                lock <= 1'b0;
            end

            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (mem.resp_valid && fifo_empty) resp_err <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only read after it was
    // written, and the reset pointers/count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= grant_idx;
    end

`ifdef BULK_ARB_PERF_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_perf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_count[i] <= '0;
            end else if (accept && grant_idx == idx_t'(i) && grant_count[i] != '1) begin
                grant_count[i] <= grant_count[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/bulk_read_arbiter.md
BULK_READ_ARBITER -- requirements
Module: bulk_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requesting channels, legal range 2..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the in-order response-routing FIFO, power of two, range 1..16.
REQ-003 SHALL take ADDR_W, DATA_W and LINE_SIZE from the bulk_read_interface instances; all channels and the memory port share the same values.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ch[NUM_CH], bulk_read_interface.slave: requester channels, index 0..NUM_CH-1.
REQ-007 SHALL have port mem, bulk_read_interface.master: the single downstream memory port.
REQ-008 SHALL have port resp_err, output, 1 bit: sticky flag, set by a response arriving with no outstanding request.

Function
REQ-009 SHALL assert mem.req_valid when an unmasked channel has req_valid, the FIFO is not full and reset is released; mem.req_* SHALL be the granted channel's req_addr/req_write/req_wdata/req_wstrb, otherwise all zero.
REQ-010 SHALL drive only the granted channel's req_ready as mem.req_ready && !fifo_full; all other channels' req_ready SHALL be 0.
REQ-011 SHALL treat a transfer as accepted when mem.req_valid && mem.req_ready are both high in the same cycle.
REQ-012 SHALL select the grant round-robin: search starts at rr_ptr, then wraps through NUM_CH-1 to 0; after an accept on channel k, rr_ptr <= (k+1) mod NUM_CH.
REQ-013 SHALL lock the grant when mem.req_valid=1 && mem.req_ready=0; the same channel stays granted until accepted, even if a higher-priority channel raises req_valid.
REQ-014 SHALL mask every channel except the dumper while any channel has dumping_cache=1; if several channels are dumping, the lowest dumping index wins; an existing lock overrides masking.
REQ-015 SHALL push the granted channel index into the FIFO on each accept; the FIFO width is clog2(NUM_CH).
REQ-016 SHALL treat mem.resp_valid as the response to the FIFO head: assert only ch[head].resp_valid, hold all others at 0, and pop the head in that cycle.
REQ-017 SHALL broadcast mem.resp_rdata to every channel's resp_rdata unconditionally.
REQ-018 SHALL hold mem.req_valid low when the FIFO is full, even if a pop occurs in the same cycle.
REQ-019 SHALL complete both a push and a pop in the same cycle when the FIFO is non-empty and not full; the count is unchanged.
REQ-020 SHALL, on mem.resp_valid with an empty FIFO, drive no channel resp_valid, leave the count unchanged and set resp_err=1 until reset.
REQ-021 SHALL wrap the FIFO read and write pointers modulo MAX_OUTSTANDING.
REQ-022 SHALL have zero-cycle combinational request latency from a channel to mem and zero-cycle response routing.

Reset
REQ-023 SHALL, while rst_n=0, clear rr_ptr, lock, FIFO pointers, count and resp_err, and force mem.req_valid=0 and every ch req_ready=0 and resp_valid=0.
REQ-024 SHALL discard in-flight requests on reset mid-operation; responses after reset are handled per REQ-020.

Configuration
REQ-025 SHALL, with BULK_ARB_PERF_EN defined, add output grant_count[NUM_CH], 32 bits each: saturating count of accepts per channel, reset to 0.
REQ-026 SHALL, with BULK_ARB_PERF_EN undefined, have neither the grant_count port nor its counters; all other behaviour is identical.

Verification
REQ-027 SHALL cover: NUM_CH=3, all channels valid, mem ready every cycle -> accepts in order 0,1,2,0; rr_ptr=1 after the first accept.
REQ-028 SHALL cover: ch1 valid with addr 0x40 and mem.req_ready=0 for 3 cycles while ch0 rises -> mem.req_addr holds 0x40 until accept, then ch0 is served.
REQ-029 SHALL cover: ch2 dumping_cache=1 with ch0/ch1 valid -> only ch2 is accepted until dumping_cache drops.
REQ-030 SHALL cover: MAX_OUTSTANDING=4, 4 accepts with no responses -> mem.req_valid=0; one resp_valid -> ch[first].resp_valid=1, next cycle issue resumes.
REQ-031 SHALL cover: responses returned for accepts from ch0,ch2,ch1 -> resp_valid pulses on ch0, then ch2, then ch1, with rdata broadcast to all.
REQ-032 SHALL cover: mem.resp_valid with the FIFO empty -> no channel resp_valid and resp_err=1; rst_n pulse -> resp_err=0.
